// File: rtl/instruction_change_queue.sv
// Instruction change queue: stability-filters the incoming word, commits changed words into a
// first-word-fall-through FIFO and pulses NOT_EQU once per committed word.
module instruction_change_queue #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter bit          ALLOW_REPEAT  = 1'b0
) (
    input  logic                       HF_CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           INSTRUCTION,
    input  logic                       IN_VALID,
    input  logic                       FLUSH,
    input  logic                       OUT_READY,
    output logic                       OUT_VALID,
    output logic [WIDTH-1:0]           OUT_INSTRUCTION,
    output logic                       NOT_EQU,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       OVERFLOW
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SW   = $clog2(STABLE_CYCLES + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [SW-1:0]   SMax    = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0]   SOne    = SW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [SW-1:0]    s_q, s_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             last_valid_q, last_valid_d;
    logic             not_equ_q, not_equ_d;
    logic             overflow_q, overflow_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic commit;
    logic push;
    logic pop;
    logic full;

    always_comb begin
        cand_d       = cand_q;
        s_d          = s_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        not_equ_d    = 1'b0;
        overflow_d   = overflow_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        accept       = 1'b0;
        commit       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        full         = (count_q == CntFull);

        if (FLUSH) begin
            // CAND is deliberately kept so a held word re-accepts after the flush.
            s_d          = '0;
            last_valid_d = 1'b0;
            overflow_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (!IN_VALID) begin
                s_d = '0;
            end else if (INSTRUCTION != cand_q) begin
                cand_d = INSTRUCTION;
                s_d    = SOne;
                // A new word starts a fresh run, so a single-cycle filter accepts it at once.
                accept = (STABLE_CYCLES == 32'd1);
            end else if (s_q < SMax) begin
                s_d    = s_q + SOne;
                accept = (s_d == SMax);
            end

            commit = accept && (!last_valid_q || (INSTRUCTION != last_q) || ALLOW_REPEAT);

            if (commit) begin
                last_d       = INSTRUCTION;
                last_valid_d = 1'b1;
                not_equ_d    = 1'b1;
            end

            pop  = (count_q != '0) && OUT_READY;
            // A simultaneous pop frees the slot, so a full FIFO can still take the word.
            push = commit && (!full || pop);

            if (commit && full && !pop) begin
                overflow_d = 1'b1;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge HF_CLK or negedge RST) begin
        if (!RST) begin
            cand_q       <= '0;
            s_q          <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            not_equ_q    <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            cand_q       <= cand_d;
            s_q          <= s_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            not_equ_q    <= not_equ_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the head word is masked whenever the FIFO is empty.
    always_ff @(posedge HF_CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= INSTRUCTION;
        end
    end

    always_comb begin
        OUT_VALID       = (count_q != '0);
        OUT_INSTRUCTION = OUT_VALID ? mem[rd_ptr_q] : '0;
        NOT_EQU         = not_equ_q;
        COUNT           = count_q;
        OVERFLOW        = overflow_q;
    end

endmodule

// File: tb/tb_instruction_change_queue.sv
// Bench for instruction_change_queue: two instances (repeat off/on) share one directed stimulus
// and are checked every cycle against a queue-level reference model plus literal expectations.
module tb_instruction_change_queue;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  instr = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          ready = 1'b0;

    logic          ov0, ne0, of0, ov1, ne1, of1;
    logic [W-1:0]  oi0, oi1;
    logic [2:0]    cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_change_queue #(
        .WIDTH(W), .DEPTH(D), .STABLE_CYCLES(SC), .ALLOW_REPEAT(1'b0)
    ) dut0 (
        .HF_CLK(clk), .RST(rst), .INSTRUCTION(instr), .IN_VALID(in_valid), .FLUSH(flush),
        .OUT_READY(ready), .OUT_VALID(ov0), .OUT_INSTRUCTION(oi0), .NOT_EQU(ne0),
        .COUNT(cnt0), .OVERFLOW(of0)
    );

    instruction_change_queue #(
        .WIDTH(W), .DEPTH(D), .STABLE_CYCLES(SC), .ALLOW_REPEAT(1'b1)
    ) dut1 (
        .HF_CLK(clk), .RST(rst), .INSTRUCTION(instr), .IN_VALID(in_valid), .FLUSH(flush),
        .OUT_READY(ready), .OUT_VALID(ov1), .OUT_INSTRUCTION(oi1), .NOT_EQU(ne1),
        .COUNT(cnt1), .OVERFLOW(of1)
    );

    // Reference model state, index 0 = repeat off, 1 = repeat on.
    int           run [2];
    logic [W-1:0] prev [2];
    logic [W-1:0] last [2];
    bit           lv [2];
    bit           mne [2];
    bit           movf [2];
    logic [W-1:0] fq [2][64];
    int           head [2];
    int           size [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; prev[k] = '0; last[k] = '0; lv[k] = 0; mne[k] = 0; movf[k] = 0;
            head[k] = 0; size[k] = 0;
        end
    endtask

    task automatic model_step();
        bit acc, com, pop;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                size[k] = 0; head[k] = 0; movf[k] = 0; lv[k] = 0; run[k] = 0; mne[k] = 0;
            end else begin
                pop = (size[k] != 0) && ready;
                acc = 0;
                if (!in_valid) begin
                    run[k] = 0;
                end else begin
                    if (instr != prev[k]) begin
                        prev[k] = instr;
                        run[k]  = 1;
                    end else begin
                        run[k]++;
                    end
                    acc = (run[k] == SC);
                end
                com = acc && (!lv[k] || instr != last[k] || k == 1);
                mne[k] = com;
                if (com) begin
                    last[k] = instr;
                    lv[k]   = 1;
                end
                if (pop) begin
                    head[k] = (head[k] + 1) % 64;
                    size[k]--;
                end
                if (com) begin
                    if (size[k] < D) begin
                        fq[k][(head[k] + size[k]) % 64] = instr;
                        size[k]++;
                    end else begin
                        movf[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input int k, input logic ov, input logic [W-1:0] oi, input logic ne,
                       input logic [2:0] c, input logic of);
        logic [W-1:0] eo;
        eo = (size[k] != 0) ? fq[k][head[k]] : '0;
        check($sformatf("cmp%0d OUT_VALID", k), 64'(ov), 64'(size[k] != 0));
        check($sformatf("cmp%0d OUT_INSTRUCTION", k), 64'(oi), 64'(eo));
        check($sformatf("cmp%0d NOT_EQU", k), 64'(ne), 64'(mne[k]));
        check($sformatf("cmp%0d COUNT", k), 64'(c), 64'(size[k]));
        check($sformatf("cmp%0d OVERFLOW", k), 64'(of), 64'(movf[k]));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, ov0, oi0, ne0, cnt0, of0);
            cmp(1, ov1, oi1, ne1, cnt1, of1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string nm, input int k, input int c, input bit ne,
                       input logic [W-1:0] out);
        check({nm, (k == 0) ? " count0" : " count1"}, 64'((k == 0) ? cnt0 : cnt1), 64'(c));
        check({nm, (k == 0) ? " ne0" : " ne1"}, 64'((k == 0) ? ne0 : ne1), 64'(ne));
        check({nm, (k == 0) ? " out0" : " out1"}, 64'((k == 0) ? oi0 : oi1), 64'(out));
    endtask

    task automatic lit_ovf(input string nm, input bit exp);
        check({nm, " ovf0"}, 64'(of0), 64'(exp));
        check({nm, " ovf1"}, 64'(of1), 64'(exp));
    endtask

    initial begin
        // Reset held with random inputs.
        repeat (5) begin
            instr    = $urandom;
            in_valid = 1'($urandom_range(0, 1));
            flush    = 1'($urandom_range(0, 1));
            ready    = 1'($urandom_range(0, 1));
            cyc(1);
            lit("reset", 0, 0, 0, '0);
            lit("reset", 1, 0, 0, '0);
            lit_ovf("reset", 0);
        end
        in_valid = 0; flush = 0; ready = 0; instr = '0;
        rst = 1;
        cyc(2);
        lit("post_reset", 0, 0, 0, '0);

        // Defaults: single commit at t=2, no recommit of the same word.
        instr = 32'hE3A01005; in_valid = 1;
        cyc(1);
        lit("dflt_t1", 0, 0, 0, '0);
        cyc(1);
        lit("dflt_t2", 0, 1, 1, 32'hE3A01005);
        cyc(1);
        lit("dflt_t3", 0, 1, 0, 32'hE3A01005);
        cyc(3);
        in_valid = 0;
        cyc(1);
        in_valid = 1;
        cyc(3);
        lit("dflt_redrive", 0, 1, 0, 32'hE3A01005);
        lit("rep_redrive", 1, 2, 0, 32'hE3A01005);
        in_valid = 0; ready = 1;
        cyc(3);
        lit("drain1", 0, 0, 0, '0);
        lit("drain1", 1, 0, 0, '0);

        // Glitch rejection.
        ready = 0;
        instr = 32'h11111111; in_valid = 1;
        cyc(1);
        instr = 32'h22222222;
        cyc(1);
        lit("glitch_a", 0, 0, 0, '0);
        cyc(1);
        lit("glitch_b", 0, 1, 1, 32'h22222222);
        cyc(1);
        lit("glitch_c", 0, 1, 0, 32'h22222222);
        in_valid = 0; ready = 1;
        cyc(2);
        lit("drain2", 0, 0, 0, '0);

        // Overflow: five words into a four-entry FIFO.
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            instr = 32'hA0000001 + 32'(i); in_valid = 1;
            cyc(2);
        end
        in_valid = 0;
        cyc(1);
        lit("ovf_full", 0, 4, 0, 32'hA0000001);
        lit_ovf("ovf_full", 1);
        ready = 1;
        cyc(1);
        lit("ovf_pop1", 0, 3, 0, 32'hA0000002);
        cyc(1);
        lit("ovf_pop2", 0, 2, 0, 32'hA0000003);
        cyc(1);
        lit("ovf_pop3", 0, 1, 0, 32'hA0000004);
        cyc(1);
        lit("ovf_pop4", 0, 0, 0, '0);
        lit_ovf("ovf_sticky", 1);

        // Full FIFO with simultaneous push and pop.
        ready = 0; flush = 1;
        cyc(1);
        flush = 0;
        lit("flush1", 0, 0, 0, '0);
        lit_ovf("flush1", 0);
        for (int i = 0; i < 4; i++) begin
            instr = 32'hB0000001 + 32'(i); in_valid = 1;
            cyc(2);
        end
        lit("pp_full", 0, 4, 1, 32'hB0000001);
        instr = 32'hB00000FF;
        cyc(1);
        ready = 1;
        cyc(1);
        ready = 0; in_valid = 0;
        lit("pp_after", 0, 4, 1, 32'hB0000002);
        lit_ovf("pp_after", 0);
        ready = 1;
        cyc(1);
        lit("pp_pop1", 0, 3, 0, 32'hB0000003);
        cyc(1);
        lit("pp_pop2", 0, 2, 0, 32'hB0000004);
        cyc(1);
        lit("pp_pop3", 0, 1, 0, 32'hB00000FF);
        cyc(1);
        lit("pp_pop4", 0, 0, 0, '0);

        // Repeat mode and flush recommit.
        ready = 0;
        instr = 32'hAAAA0000; in_valid = 1;
        cyc(2);
        lit("rep_c1", 0, 1, 1, 32'hAAAA0000);
        lit("rep_c1", 1, 1, 1, 32'hAAAA0000);
        in_valid = 0;
        cyc(1);
        in_valid = 1;
        cyc(2);
        lit("rep_c2", 0, 1, 0, 32'hAAAA0000);
        lit("rep_c2", 1, 2, 1, 32'hAAAA0000);
        flush = 1;
        cyc(1);
        flush = 0;
        lit("rep_flush", 0, 0, 0, '0);
        lit("rep_flush", 1, 0, 0, '0);
        lit_ovf("rep_flush", 0);
        cyc(1);
        lit("rep_wait", 1, 0, 0, '0);
        cyc(1);
        lit("rep_recommit", 0, 1, 1, 32'hAAAA0000);
        lit("rep_recommit", 1, 1, 1, 32'hAAAA0000);

        in_valid = 0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
